// File: rtl/ram_1p_arb.sv
// ram_1p_arb: round-robin two-requester front end for a 1-cycle single-port SRAM.
// Optional zeroing sweep after reset: define RAM_ARB_INIT_EN.
module ram_1p_arb #(
  parameter int Width = 32,
  parameter int Depth = 128,
  localparam int Aw = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_req_i,
  input  logic             a_we_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  output logic             a_gnt_o,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  input  logic             b_req_i,
  input  logic             b_we_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Width-1:0] b_wmask_i,
  output logic             b_gnt_o,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i,
  output logic             init_done_o
);

  logic          run;
  logic          sweep;
  logic [Aw-1:0] sweep_addr;
  logic          a_gnt, b_gnt;
  logic          prio_q, prio_d;
  logic          a_rvalid_q, a_rd_q;
  logic          b_rvalid_q, b_rd_q;

`ifdef RAM_ARB_INIT_EN
  localparam logic [0:0] StInit = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [Aw-1:0] cnt_q, cnt_d;

  assign run        = (state_q == StRun);
  assign sweep      = ~run & ~rst_i;
  assign sweep_addr = cnt_q;

  // Sweep counter walks every word once, then hands over to RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!run) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == Aw'(Depth - 1)) begin
        state_d = StRun;
      end
    end
  end

  // FSM and sweep counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign run        = 1'b1;
  assign sweep      = 1'b0;
  assign sweep_addr = '0;
`endif

  // prio_q = 0 favours A, 1 favours B on contention
  assign a_gnt = run & a_req_i & (~b_req_i | ~prio_q);
  assign b_gnt = run & b_req_i & (~a_req_i | prio_q);

  // Priority flips away from whoever was just granted
  always_comb begin
    prio_d = prio_q;
    if (a_gnt) begin
      prio_d = 1'b1;
    end else if (b_gnt) begin
      prio_d = 1'b0;
    end
  end

  // Single RAM port mux; zeroed when idle
  always_comb begin
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    unique case (1'b1)
      sweep: begin
        ram_req_o   = 1'b1;
        ram_write_o = 1'b1;
        ram_addr_o  = sweep_addr;
        ram_wmask_o = '1;
      end
      a_gnt: begin
        ram_req_o   = 1'b1;
        ram_write_o = a_we_i;
        ram_addr_o  = a_addr_i;
        ram_wdata_o = a_wdata_i;
        ram_wmask_o = a_wmask_i;
      end
      b_gnt: begin
        ram_req_o   = 1'b1;
        ram_write_o = b_we_i;
        ram_addr_o  = b_addr_i;
        ram_wdata_o = b_wdata_i;
        ram_wmask_o = b_wmask_i;
      end
      default: begin
      end
    endcase
  end

  // Response stage tracks which requester owns the RAM's next output
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q     <= 1'b0;
      a_rvalid_q <= 1'b0;
      a_rd_q     <= 1'b0;
      b_rvalid_q <= 1'b0;
      b_rd_q     <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      a_rvalid_q <= a_gnt;
      a_rd_q     <= a_gnt & ~a_we_i;
      b_rvalid_q <= b_gnt;
      b_rd_q     <= b_gnt & ~b_we_i;
    end
  end

  assign a_gnt_o     = a_gnt;
  assign b_gnt_o     = b_gnt;
  assign a_rvalid_o  = a_rvalid_q;
  assign b_rvalid_o  = b_rvalid_q;
  assign a_rdata_o   = a_rd_q ? ram_rdata_i : '0;
  assign b_rdata_o   = b_rd_q ? ram_rdata_i : '0;
  assign init_done_o = run & ~rst_i;

endmodule

// File: tb/tb_ram_1p_arb.sv
// tb_ram_1p_arb: directed stimulus with a cycle-stamped response scoreboard.
// Build with RAM_ARB_INIT_EN to also exercise the zeroing sweep.
module tb_ram_1p_arb;
  localparam int W = 32;
  localparam int D = 16;
  localparam int A = 4;

`ifdef RAM_ARB_INIT_EN
  localparam logic [W-1:0] C5 = 32'h0;
  localparam logic [W-1:0] C3 = 32'h0;
`else
  localparam logic [W-1:0] C5 = 32'hDEADBEEF;
  localparam logic [W-1:0] C3 = 32'hFFFF00FF;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [A-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0] a_wd = '0, a_wm = '0, b_wd = '0, b_wm = '0;
  logic a_gnt, a_rv, b_gnt, b_rv;
  logic [W-1:0] a_rd, b_rd;
  logic r_req, r_wr, done;
  logic [A-1:0] r_addr;
  logic [W-1:0] r_wd, r_wm;
  logic [W-1:0] r_rd = '0;

  logic [W-1:0] mem [D];
  int cyc = 0;
  int checks = 0;
  int fails = 0;

  typedef struct {
    int cyc;
    logic [W-1:0] d;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];

  ram_1p_arb #(.Width(W), .Depth(D)) dut (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr),
    .a_wdata_i(a_wd), .a_wmask_i(a_wm),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rv), .a_rdata_o(a_rd),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr),
    .b_wdata_i(b_wd), .b_wmask_i(b_wm),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rv), .b_rdata_o(b_rd),
    .ram_req_o(r_req), .ram_write_o(r_wr), .ram_addr_o(r_addr),
    .ram_wdata_o(r_wd), .ram_wmask_o(r_wm), .ram_rdata_i(r_rd),
    .init_done_o(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < D; i++) mem[i] = 32'hA5A5A5A5;
  end

  // Behavioural SRAM: 1-cycle read latency, bit mask on writes
  always @(posedge clk) begin
    if (r_req) begin
      if (r_wr) mem[r_addr] <= (mem[r_addr] & ~r_wm) | (r_wd & r_wm);
      else r_rd <= mem[r_addr];
    end
  end

  function automatic void chk(string n, logic [W-1:0] got, logic [W-1:0] ex);
    checks++;
    if (got !== ex) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", n, got, ex);
    end
  endfunction

  // Monitor: every response must match the head of its queue, 1 cycle after grant
  always @(negedge clk) begin
    exp_t e;
    if (a_rv) begin
      if (qa.size() == 0) chk("a_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_rsp_latency", cyc, e.cyc + 1);
        chk("a_rdata", a_rd, e.d);
      end
    end
    if (b_rv) begin
      if (qb.size() == 0) chk("b_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_rsp_latency", cyc, e.cyc + 1);
        chk("b_rdata", b_rd, e.d);
      end
    end
  end

  task automatic set_a(input logic we, input logic [A-1:0] ad,
                       input logic [W-1:0] wd, input logic [W-1:0] wm);
    a_req = 1; a_we = we; a_addr = ad; a_wd = wd; a_wm = wm;
  endtask

  task automatic set_b(input logic we, input logic [A-1:0] ad,
                       input logic [W-1:0] wd, input logic [W-1:0] wm);
    b_req = 1; b_we = we; b_addr = ad; b_wd = wd; b_wm = wm;
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_addr = '0; a_wd = '0; a_wm = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wd = '0; b_wm = '0;
  endtask

  // Called at posedge+1 with inputs driven; checks grants, queues responses
  task automatic tick(input logic ga, input logic gb,
                      input logic [W-1:0] da, input logic [W-1:0] db);
    exp_t e;
    #3;
    chk("init_done", {31'd0, done}, 32'd1);
    chk("a_gnt", {31'd0, a_gnt}, {31'd0, ga});
    chk("b_gnt", {31'd0, b_gnt}, {31'd0, gb});
    chk("ram_req", {31'd0, r_req}, {31'd0, ga | gb});
    if (ga) chk("ram_addr_a", {28'd0, r_addr}, {28'd0, a_addr});
    if (gb && !ga) chk("ram_addr_b", {28'd0, r_addr}, {28'd0, b_addr});
    if (ga) begin e.cyc = cyc; e.d = da; qa.push_back(e); end
    if (gb) begin e.cyc = cyc; e.d = db; qb.push_back(e); end
    @(posedge clk); #1;
  endtask

  // One reset edge, then (with the sweep) Depth cycles of INIT
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    chk("rst_a_rvalid", {31'd0, a_rv}, 32'd0);
    chk("rst_b_rvalid", {31'd0, b_rv}, 32'd0);
    chk("rst_init_done", {31'd0, done}, 32'd0);
    rst = 0;
`ifdef RAM_ARB_INIT_EN
    for (int i = 0; i < D; i++) begin
      #3;
      chk("swp_done", {31'd0, done}, 32'd0);
      chk("swp_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
      chk("swp_req", {30'd0, r_req, r_wr}, 32'd3);
      chk("swp_addr", {28'd0, r_addr}, i);
      chk("swp_wdata", r_wd, 32'd0);
      chk("swp_wmask", r_wm, 32'hFFFFFFFF);
      @(posedge clk); #1;
    end
`endif
  endtask

  initial begin
    idle();
    @(posedge clk); #1;
    #3;
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
    chk("reset_ram_req", {31'd0, r_req}, 32'd0);
    chk("reset_ram_addr", {28'd0, r_addr}, 32'd0);
    chk("reset_ram_wmask", r_wm, 32'd0);
    chk("reset_rvalid", {30'd0, a_rv, b_rv}, 32'd0);
    do_reset();

    // Single write then read on A
    set_a(1, 4'd5, 32'hDEADBEEF, 32'hFFFFFFFF); tick(1, 0, 0, 0);
    set_a(0, 4'd5, 0, 0);                       tick(1, 0, 32'hDEADBEEF, 0);
    // Masked write from B over an all-ones word
    idle();
    set_a(1, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF); tick(1, 0, 0, 0);
    idle();
    set_b(1, 4'd3, 32'h0, 32'h0000FF00);        tick(0, 1, 0, 0);
    set_b(0, 4'd3, 0, 0);                       tick(0, 1, 0, 32'hFFFF00FF);
    idle();                                     tick(0, 0, 0, 0);
    #3;
    chk("idle_addr", {28'd0, r_addr}, 32'd0);
    chk("idle_wdata", r_wd, 32'd0);
    @(posedge clk); #1;

    // Contention straight after reset: strict alternation starting at A
    do_reset();
    set_a(0, 4'd5, 0, 0);
    set_b(0, 4'd3, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, C5, 0);
      tick(0, 1, 0, C3);
    end

    // Reset in the cycle after an A read grant drops the response
    idle();
    set_a(0, 4'd5, 0, 0);
    #3;
    chk("midrst_a_gnt", {31'd0, a_gnt}, 32'd1);
    set_b(0, 4'd3, 0, 0);
    do_reset();
    tick(1, 0, C5, 0);
    tick(0, 1, 0, C3);

`ifdef RAM_ARB_INIT_EN
    // Preloaded word is cleared by the sweep while A stalls
    idle();
    set_a(1, 4'd9, 32'h1234, 32'hFFFFFFFF); tick(1, 0, 0, 0);
    set_a(0, 4'd9, 0, 0);                   tick(1, 0, 32'h1234, 0);
    do_reset();
    tick(1, 0, 32'h0, 0);
`endif

    idle();
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    chk("qa_drained", qa.size(), 32'd0);
    chk("qb_drained", qb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/ram_1p_arb.md
Name: ram_1p_arb

Overview:
- Two-requester front end for the synchronous single-port SRAM primitive (1-cycle read latency, full bit write mask).
- Arbitrates requesters A and B with round-robin priority, drives the single RAM port, and routes read data and acks back to the owning requester.
- Sits between a core-side port (A) and a debug/DMA-side port (B) sharing one scratch RAM.

Parameters:
- Width, 32, data width in bits.
- Depth, 128, number of words.
- Aw, $clog2(Depth), address width (localparam, derived).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- a_req_i  in  1  A request
- a_we_i  in  1  A write enable (1 = write, 0 = read)
- a_addr_i  in  Aw  A word address
- a_wdata_i  in  Width  A write data
- a_wmask_i  in  Width  A bit write mask
- a_gnt_o  out  1  A granted this cycle
- a_rvalid_o  out  1  A response (read data or write ack)
- a_rdata_o  out  Width  A read data
- b_*  same set as A, for requester B
- ram_req_o  out  1  to RAM req_i
- ram_write_o  out  1  to RAM write_i
- ram_addr_o  out  Aw  to RAM addr_i
- ram_wdata_o  out  Width  to RAM wdata_i
- ram_wmask_o  out  Width  to RAM wmask_i
- ram_rdata_i  in  Width  from RAM rdata_o
- init_done_o  out  1  arbiter accepting requests

Behaviour:
- Single clock; all state updates on the rising edge of clk_i. Reset is synchronous and active-high: rst_i sampled high clears state on that edge.
- Reset values:
  - gnt, rvalid, ram_req_o, ram_write_o, init_done_o: 0.
  - All rdata, ram_addr_o, ram_wdata_o, ram_wmask_o: 0.
  - Priority pointer: A.
- FSM states INIT and RUN. Reset enters INIT when RAM_ARB_INIT_EN is defined, otherwise RUN.

RUN state:
- Grant decision and RAM drive are combinational from req inputs in the same cycle.
- Only one requester: it is granted.
- Both requesting: grant the one not granted most recently (pointer). Pointer updates to the granted requester on every grant.
- Ungranted requester keeps req high with stable fields until granted. This is a requirement on the requester; no buffering is done here.
- ram_req_o = a_gnt_o | b_gnt_o. Granted requester's we/addr/wdata/wmask are muxed onto ram_*. When idle, ram_* fields are 0.
- Response register stage: cycle after a grant, that requester's rvalid_o = 1 for exactly one cycle, for reads and writes alike.
- rdata_o = ram_rdata_i for a read response; 0 otherwise, including write acks and the other requester's responses.
- Back-to-back grants every cycle are allowed: throughput 1 access/cycle.
- Contention: strict alternation, no starvation. Worst-case wait is 1 cycle.
- init_done_o = 1.

Reset mid-operation:
- Pending response is dropped: no rvalid on the cycle after reset.
- Pointer returns to A.
- With RAM_ARB_INIT_EN defined, the init sweep restarts from address 0.

Optional Feature:
- Macro: RAM_ARB_INIT_EN.
- Defined:
  - After reset, FSM is in INIT with an Aw-bit sweep counter at 0.
  - Each cycle: ram_req_o = 1, ram_write_o = 1, ram_addr_o = counter, ram_wdata_o = 0, ram_wmask_o = all ones; counter increments.
  - After writing Depth-1, FSM moves to RUN and init_done_o goes 1 on the next cycle.
  - During INIT: gnt and rvalid stay 0, requests are ignored, and requesters stall.
  - Sweep takes exactly Depth cycles after reset deassertion.
- Undefined:
  - No INIT state and no counter.
  - init_done_o rises the first cycle after reset deasserts.
  - A request in that first cycle is granted.

Test Plan:
- Single read: write A addr 5 data 32'hDEADBEEF mask all ones, then A read addr 5 -> a_gnt_o same cycle, a_rvalid_o next cycle with a_rdata_o = 32'hDEADBEEF, b_rvalid_o = 0.
- Contention: A and B both read every cycle for 6 cycles after reset -> grants A,B,A,B,A,B; each rvalid lags its grant by 1 cycle; no bubbles on ram_req_o.
- Masked write: write 32'hFFFFFFFF to addr 3, then B write 32'h0 with mask 32'h0000FF00 -> B read addr 3 returns 32'hFFFF00FF.
- Write ack: B write -> b_rvalid_o pulse 1 cycle later with b_rdata_o = 0.
- Reset mid-read: grant A read, assert rst_i next edge -> a_rvalid_o stays 0; first contended grant after reset goes to A.
- With RAM_ARB_INIT_EN, Depth=16: preload addr 9 = 32'h1234, reset, hold a_req_i high -> no grant for 16 cycles, init_done_o rises at cycle 17, A read addr 9 returns 0.
